// File: rtl/eth_phy_10g_tx_gearbox_if.sv
// Block-in / SERDES-word-out bundle for the 10G TX 64b/66b gearbox.
// Upstream (encoder side) uses master; the gearbox uses slave.
interface eth_phy_10g_tx_gearbox_if #(
  parameter int DATA_WIDTH = 64,
  parameter int HDR_WIDTH  = 2
);
  logic [DATA_WIDTH-1:0] encoded_tx_data;
  logic [HDR_WIDTH-1:0]  encoded_tx_hdr;
  logic                  encoded_tx_ready;
  logic [DATA_WIDTH-1:0] serdes_tx_data;
  logic [5:0]            tx_seq;
  logic                  tx_bad_hdr;

  modport master (
    output encoded_tx_data,
    output encoded_tx_hdr,
    input  encoded_tx_ready,
    input  serdes_tx_data,
    input  tx_seq,
    input  tx_bad_hdr
  );

  modport slave (
    input  encoded_tx_data,
    input  encoded_tx_hdr,
    output encoded_tx_ready,
    output serdes_tx_data,
    output tx_seq,
    output tx_bad_hdr
  );
endinterface

// File: rtl/eth_phy_10g_tx_gearbox.sv
// TX 64b/66b gearbox: packs 32 x 66-bit blocks into 33 x 64-bit SERDES words per
// sequence, pausing upstream once per sequence so every sequence starts header-aligned.
module eth_phy_10g_tx_gearbox #(
  parameter int DATA_WIDTH = 64,
  parameter int HDR_WIDTH  = 2
) (
  input logic clk,
  input logic rst,
  eth_phy_10g_tx_gearbox_if.slave tx
);

  if (DATA_WIDTH != 64) begin : g_bad_data_width
    $error("eth_phy_10g_tx_gearbox: DATA_WIDTH must be 64");
  end
  if (HDR_WIDTH != 2) begin : g_bad_hdr_width
    $error("eth_phy_10g_tx_gearbox: HDR_WIDTH must be 2");
  end

  localparam int          BLK_W    = DATA_WIDTH + HDR_WIDTH;
  localparam logic [5:0]  SEQ_LAST = 6'd32;

  logic [5:0]            seq_q,  seq_d;
  logic [DATA_WIDTH-1:0] rem_q,  rem_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  bad_q,  bad_d;

  logic [BLK_W-1:0]      blk;
  logic [6:0]            shamt_l;
  logic [6:0]            shamt_r;
  logic                  ready;

  always_comb begin
    blk     = {tx.encoded_tx_data, tx.encoded_tx_hdr};
    ready   = (seq_q != SEQ_LAST);
    shamt_l = {seq_q, 1'b0};
    shamt_r = 7'd64 - shamt_l;

    // Pause slot: flush the 64 bits carried over from the 32 previous blocks.
    seq_d  = '0;
    rem_d  = '0;
    word_d = rem_q;
    bad_d  = 1'b0;

    if (ready) begin
      seq_d  = seq_q + 6'd1;
      // rem_q is always zero above bit 2s-1, so a plain OR merges the carry-over.
      word_d = rem_q | DATA_WIDTH'(blk << shamt_l);
      rem_d  = DATA_WIDTH'(blk >> shamt_r);
      bad_d  = (tx.encoded_tx_hdr[0] == tx.encoded_tx_hdr[1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seq_q  <= '0;
      rem_q  <= '0;
      word_q <= '0;
      bad_q  <= 1'b0;
    end else begin
      seq_q  <= seq_d;
      rem_q  <= rem_d;
      word_q <= word_d;
      bad_q  <= bad_d;
    end
  end

  assign tx.encoded_tx_ready = ready;
  assign tx.serdes_tx_data   = word_q;
  assign tx.tx_seq           = seq_q;
  assign tx.tx_bad_hdr       = bad_q;

endmodule

// File: tb/tb_eth_phy_10g_tx_gearbox.sv
// Directed and random checks of the TX gearbox against a bit-queue stream model.
module tb_eth_phy_10g_tx_gearbox;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   fails  = 0;

  // Stream model: bits of consumed blocks in transmit order, and cycle phase since reset.
  bit   mq[$];
  int   mseq = 0;

  eth_phy_10g_tx_gearbox_if #(.DATA_WIDTH(64), .HDR_WIDTH(2)) bus ();

  eth_phy_10g_tx_gearbox #(.DATA_WIDTH(64), .HDR_WIDTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .tx  (bus)
  );

  always #5 clk = ~clk;

  // One clock: sample pre-edge ready/seq, drive inputs, advance model, step to edge+1.
  task automatic run_cycle(input logic r, input logic [63:0] d, input logic [1:0] h,
                           output logic obs_rdy, output logic [5:0] obs_seq,
                           output logic exp_rdy, output int exp_seq,
                           output logic [63:0] exp_w, output logic exp_bad);
    obs_rdy = bus.encoded_tx_ready;
    obs_seq = bus.tx_seq;
    rst = r;
    bus.encoded_tx_data = d;
    bus.encoded_tx_hdr  = h;
    exp_rdy = (mseq != 32);
    exp_seq = mseq;
    exp_w   = '0;
    exp_bad = 1'b0;
    if (r) begin
      mq.delete();
      mseq = 0;
    end else begin
      if (exp_rdy) begin
        for (int i = 0; i < 2; i++)  mq.push_back(h[i]);
        for (int i = 0; i < 64; i++) mq.push_back(d[i]);
      end
      exp_bad = exp_rdy && (h == 2'b00 || h == 2'b11);
      for (int i = 0; i < 64; i++) exp_w[i] = mq.pop_front();
      mseq = (mseq == 32) ? 0 : mseq + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    logic orr, er, eb; logic [5:0] os; int es; logic [63:0] ew;
    run_cycle(1'b1, '0, 2'b01, orr, os, er, es, ew, eb);
    run_cycle(1'b1, '0, 2'b01, orr, os, er, es, ew, eb);
  endtask

  task automatic test_reset();
    logic orr, er, eb; logic [5:0] os; int es; logic [63:0] ew;
    rst = 1'b1;
    bus.encoded_tx_data = '0;
    bus.encoded_tx_hdr  = 2'b01;
    repeat (3) @(posedge clk);
    #1;
    mq.delete();
    mseq = 0;
    checks++; if (bus.serdes_tx_data !== 64'h0) begin fails++; $display("FAIL reset_data got=%h exp=0", bus.serdes_tx_data); end
    checks++; if (bus.tx_seq !== 6'd0) begin fails++; $display("FAIL reset_seq got=%0d exp=0", bus.tx_seq); end
    checks++; if (bus.encoded_tx_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", bus.encoded_tx_ready); end
    checks++; if (bus.tx_bad_hdr !== 1'b0) begin fails++; $display("FAIL reset_bad got=%b exp=0", bus.tx_bad_hdr); end
    run_cycle(1'b0, 64'h5555_AAAA_0000_FFFF, 2'b10, orr, os, er, es, ew, eb);
    checks++; if (orr !== 1'b1) begin fails++; $display("FAIL release_ready0 got=%b exp=1", orr); end
    checks++; if (bus.encoded_tx_ready !== 1'b1) begin fails++; $display("FAIL release_ready1 got=%b exp=1", bus.encoded_tx_ready); end
    checks++; if (bus.tx_seq !== 6'd1) begin fails++; $display("FAIL release_seq got=%0d exp=1", bus.tx_seq); end
  endtask

  task automatic test_first_words();
    logic orr, er, eb; logic [5:0] os; int es; logic [63:0] ew;
    do_reset();
    run_cycle(1'b0, 64'h0123456789ABCDEF, 2'b01, orr, os, er, es, ew, eb);
    checks++; if (bus.serdes_tx_data !== 64'h048D159E26AF37BD) begin fails++; $display("FAIL word0 got=%h exp=048d159e26af37bd", bus.serdes_tx_data); end
    checks++; if (bus.tx_bad_hdr !== 1'b0) begin fails++; $display("FAIL word0_bad got=%b exp=0", bus.tx_bad_hdr); end
    run_cycle(1'b0, 64'hFEDCBA9876543210, 2'b10, orr, os, er, es, ew, eb);
    checks++; if (bus.serdes_tx_data !== 64'hEDCBA98765432108) begin fails++; $display("FAIL word1 got=%h exp=edcba98765432108", bus.serdes_tx_data); end
    checks++; if (bus.serdes_tx_data !== ew) begin fails++; $display("FAIL word1_model got=%h exp=%h", bus.serdes_tx_data, ew); end
  endtask

  task automatic test_sequence();
    logic orr, er, eb; logic [5:0] os; int es; logic [63:0] ew;
    logic [63:0] d, d32;
    logic [1:0]  h;
    int k = 0;
    d32 = '0;
    do_reset();
    for (int c = 0; c < 99; c++) begin
      d = 64'h1111_2222_0000_0000 + 64'(k);
      h = k[0] ? 2'b10 : 2'b01;
      if (c == 33) d32 = d;
      run_cycle(1'b0, d, h, orr, os, er, es, ew, eb);
      checks++; if (orr !== ((c % 33) != 32)) begin fails++; $display("FAIL seq_ready c=%0d got=%b", c, orr); end
      if (orr === 1'b0) begin
        checks++; if (os !== 6'd32) begin fails++; $display("FAIL seq_pause_at c=%0d got=%0d exp=32", c, os); end
      end
      if (er) k++;
      checks++; if (bus.serdes_tx_data !== ew) begin fails++; $display("FAIL seq_word c=%0d got=%h exp=%h", c, bus.serdes_tx_data, ew); end
      if (c == 33) begin
        checks++; if (bus.serdes_tx_data !== {d32[61:0], 2'b01}) begin fails++; $display("FAIL seq_align got=%h exp=%h", bus.serdes_tx_data, {d32[61:0], 2'b01}); end
      end
    end
    checks++; if (k !== 96) begin fails++; $display("FAIL seq_consumed got=%0d exp=96", k); end
  endtask

  task automatic test_bad_header();
    logic orr, er, eb; logic [5:0] os; int es; logic [63:0] ew;
    logic [63:0] d;
    logic [1:0]  h;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      h = (k == 5) ? 2'b00 : (k == 9) ? 2'b11 : 2'b01;
      d = {$urandom, $urandom};
      run_cycle(1'b0, d, h, orr, os, er, es, ew, eb);
      checks++; if (bus.tx_bad_hdr !== (k == 5 || k == 9)) begin fails++; $display("FAIL bad_hdr k=%0d got=%b", k, bus.tx_bad_hdr); end
      checks++; if (bus.serdes_tx_data !== ew) begin fails++; $display("FAIL bad_word k=%0d got=%h exp=%h", k, bus.serdes_tx_data, ew); end
    end
  endtask

  task automatic test_mid_reset();
    logic orr, er, eb; logic [5:0] os; int es; logic [63:0] ew;
    logic [63:0] d;
    int n = 0;
    do_reset();
    while (bus.tx_seq !== 6'd17 && n < 40) begin
      run_cycle(1'b0, {$urandom, $urandom}, 2'b10, orr, os, er, es, ew, eb);
      n++;
    end
    checks++; if (bus.tx_seq !== 6'd17) begin fails++; $display("FAIL mid_reach got=%0d exp=17", bus.tx_seq); end
    run_cycle(1'b1, {$urandom, $urandom}, 2'b01, orr, os, er, es, ew, eb);
    checks++; if (bus.tx_seq !== 6'd0) begin fails++; $display("FAIL mid_seq got=%0d exp=0", bus.tx_seq); end
    checks++; if (bus.encoded_tx_ready !== 1'b1) begin fails++; $display("FAIL mid_ready got=%b exp=1", bus.encoded_tx_ready); end
    checks++; if (bus.serdes_tx_data !== 64'h0) begin fails++; $display("FAIL mid_data got=%h exp=0", bus.serdes_tx_data); end
    d = 64'hC0FF_EE00_1234_5678;
    run_cycle(1'b0, d, 2'b10, orr, os, er, es, ew, eb);
    checks++; if (bus.serdes_tx_data !== {d[61:0], 2'b10}) begin fails++; $display("FAIL mid_first got=%h exp=%h", bus.serdes_tx_data, {d[61:0], 2'b10}); end
  endtask

  task automatic test_soak();
    logic orr, er, eb, r; logic [5:0] os; int es; logic [63:0] ew;
    do_reset();
    for (int n = 0; n < 10000; n++) begin
      r = ($urandom_range(0, 299) == 0);
      run_cycle(r, {$urandom, $urandom}, 2'($urandom), orr, os, er, es, ew, eb);
      checks++; if (orr !== er) begin fails++; $display("FAIL soak_ready n=%0d got=%b exp=%b", n, orr, er); end
      checks++; if (os !== 6'(es)) begin fails++; $display("FAIL soak_seq n=%0d got=%0d exp=%0d", n, os, es); end
      checks++; if (bus.serdes_tx_data !== ew) begin fails++; $display("FAIL soak_word n=%0d got=%h exp=%h", n, bus.serdes_tx_data, ew); end
      checks++; if (bus.tx_bad_hdr !== eb) begin fails++; $display("FAIL soak_bad n=%0d got=%b exp=%b", n, bus.tx_bad_hdr, eb); end
      if (orr === 1'b0) begin
        checks++; if (os !== 6'd32) begin fails++; $display("FAIL soak_pause n=%0d got=%0d exp=32", n, os); end
      end
    end
  endtask

  initial begin
    bus.encoded_tx_data = '0;
    bus.encoded_tx_hdr  = 2'b01;
    #1;
    test_reset();
    test_first_words();
    test_sequence();
    test_bad_header();
    test_mid_reset();
    test_soak();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
